// File: rtl/awgn_ber_checker.sv
// Hard-slicing BER checker: compares received symbol signs against FIFO-buffered reference bits over one frame.
// Build option: define QPSK_EN to slice and compare both I and Q; default build compares I only (BPSK).
module awgn_ber_checker #(
  parameter int unsigned BI        = 24,
  parameter int unsigned FRAME_LEN = 320000,
  parameter int unsigned DLY_DEPTH = 16,
  parameter int unsigned CNT_W     = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                ref_valid,
  input  logic [1:0]          ref_bits,
  output logic                ref_ready,
  input  logic                rx_valid,
  input  logic [BI-1:0]       rx_real,
  input  logic [BI-1:0]       rx_imag,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    sym_count,
  output logic [CNT_W:0]      err_count,
  output logic                underflow
);

  localparam int unsigned PTR_W = $clog2(DLY_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
`ifdef QPSK_EN
  localparam int unsigned REF_W = 2;
`else
  localparam int unsigned REF_W = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]   sym_q, sym_d;
  logic [CNT_W:0]     err_q, err_d;
  logic               unf_q, unf_d;
  logic               busy_q, busy_d, done_q, done_d, rdy_q, rdy_d;
  logic [REF_W-1:0]   mem_q [DLY_DEPTH];

  logic               push, pop;
  logic [REF_W-1:0]   decided, ref_head, diff;
  logic [1:0]         nerr;
  logic [CNT_W+1:0]   err_sum;
  logic               unused_bits;

  // Sign bit is the hard decision: negative decides 1, zero decides 0.
`ifdef QPSK_EN
  assign decided     = {rx_imag[BI-1], rx_real[BI-1]};
  assign unused_bits = ^{rx_real[BI-2:0], rx_imag[BI-2:0]};
`else
  assign decided     = rx_real[BI-1];
  assign unused_bits = ^{rx_real[BI-2:0], rx_imag, ref_bits[1]};
`endif

  assign ref_head = mem_q[rd_ptr_q];
  assign diff     = decided ^ ref_head;

  always_comb begin
    nerr = 2'd0;
    for (int i = 0; i < int'(REF_W); i++) nerr = nerr + 2'(diff[i]);
  end

  assign err_sum = (CNT_W+2)'(err_q) + (CNT_W+2)'(nerr);

  // Next-state, counters and FIFO pointer control.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    sym_d    = sym_q;
    err_d    = err_q;
    unf_d    = unf_q;
    push     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          occ_d    = '0;
          sym_d    = '0;
          err_d    = '0;
          unf_d    = 1'b0;
        end
      end
      S_RUN: begin
        push = ref_valid && rdy_q;
        if (rx_valid) begin
          if (occ_q != '0) begin
            pop   = 1'b1;
            sym_d = sym_q + CNT_W'(1);
            err_d = err_sum[CNT_W+1] ? '1 : err_sum[CNT_W:0];
            if (sym_d == CNT_W'(FRAME_LEN)) state_d = S_DONE;
          end else begin
            unf_d = 1'b1;
          end
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    rdy_d  = (state_d == S_RUN) && (occ_d < OCC_W'(DLY_DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      sym_q    <= '0;
      err_q    <= '0;
      unf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      sym_q    <= sym_d;
      err_q    <= err_d;
      unf_q    <= unf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdy_q    <= rdy_d;
    end
  end

  // Reference storage needs no reset: occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ref_bits[REF_W-1:0];
  end

  assign ref_ready = rdy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sym_count = sym_q;
  assign err_count = err_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_awgn_ber_checker.sv
// Directed bench for awgn_ber_checker: instance A (FRAME_LEN=8) and instance B (FRAME_LEN=3, CNT_W=2).
module tb_awgn_ber_checker;

`ifdef QPSK_EN
  localparam int QP = 1;
`else
  localparam int QP = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic ref_valid, rx_valid;
  logic [1:0] ref_bits;
  logic signed [23:0] rx_real, rx_imag;

  logic       rdy_a, busy_a, done_a, unf_a;
  logic [3:0] sym_a;
  logic [4:0] err_a;
  logic       rdy_b, busy_b, done_b, unf_b;
  logic [1:0] sym_b;
  logic [2:0] err_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  awgn_ber_checker #(.BI(24), .FRAME_LEN(8), .DLY_DEPTH(16), .CNT_W(4)) u_a (
    .clk(clk), .reset(rst), .start(start_a), .ref_valid(ref_valid), .ref_bits(ref_bits),
    .ref_ready(rdy_a), .rx_valid(rx_valid), .rx_real(rx_real), .rx_imag(rx_imag),
    .busy(busy_a), .done(done_a), .sym_count(sym_a), .err_count(err_a), .underflow(unf_a));

  awgn_ber_checker #(.BI(24), .FRAME_LEN(3), .DLY_DEPTH(4), .CNT_W(2)) u_b (
    .clk(clk), .reset(rst), .start(start_b), .ref_valid(ref_valid), .ref_bits(ref_bits),
    .ref_ready(rdy_b), .rx_valid(rx_valid), .rx_real(rx_real), .rx_imag(rx_imag),
    .busy(busy_b), .done(done_b), .sym_count(sym_b), .err_count(err_b), .underflow(unf_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    start_a = 0; start_b = 0; ref_valid = 0; rx_valid = 0;
  endtask

  task automatic do_reset;
    idle_in();
    rst = 1;
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic set_rx(input logic [1:0] b);
    rx_real = b[0] ? -24'sd1000 : 24'sd1000;
    rx_imag = b[1] ? -24'sd1000 : 24'sd1000;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({rdy_a, busy_a, done_a, unf_a, sym_a, err_a} !== 13'd0) begin
      failures++; $display("FAIL reset_values got=%b exp=0", {rdy_a, busy_a, done_a, unf_a, sym_a, err_a});
    end
    start_a = 1; tick(); start_a = 0;
    checks++;
    if (busy_a !== 1'b1 || rdy_a !== 1'b1) begin
      failures++; $display("FAIL start_busy got=%b%b exp=11", busy_a, rdy_a);
    end
    rx_valid = 1; set_rx(2'b00); tick(); rx_valid = 0;
    for (int i = 0; i < 6; i++) begin
      ref_valid = 1; ref_bits = 2'(i); tick();
    end
    ref_valid = 0;
    rx_valid = 1; set_rx(2'b00); tick(); rx_valid = 0;
    checks++;
    if (sym_a !== 4'd1 || unf_a !== 1'b1) begin
      failures++; $display("FAIL pre_reset got sym=%0d unf=%b exp sym=1 unf=1", sym_a, unf_a);
    end
    #1 rst = 1;
    #1;
    checks++;
    if ({rdy_a, busy_a, done_a, unf_a, sym_a, err_a} !== 13'd0) begin
      failures++; $display("FAIL async_reset got=%b exp=0", {rdy_a, busy_a, done_a, unf_a, sym_a, err_a});
    end
    tick(); rst = 0; tick();
    checks++;
    if (busy_a !== 1'b0 || rdy_a !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got=%b%b exp=00", busy_a, rdy_a);
    end
    start_a = 1; tick(); start_a = 0;
    rx_valid = 1; set_rx(2'b00); tick(); rx_valid = 0;
    checks++;
    if (unf_a !== 1'b1 || sym_a !== 4'd0) begin
      failures++; $display("FAIL fifo_discarded got unf=%b sym=%0d exp unf=1 sym=0", unf_a, sym_a);
    end
  endtask

  task automatic test_clean_frame;
    do_reset();
    start_a = 1; tick(); start_a = 0;
    for (int i = 0; i < 8; i++) begin
      ref_valid = 1; ref_bits = 2'(i % 4); tick();
    end
    ref_valid = 0;
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1; set_rx(2'(i % 4)); tick();
      if (i == 6) begin
        checks++;
        if (sym_a !== 4'd7 || done_a !== 1'b0) begin
          failures++; $display("FAIL clean_sym7 got sym=%0d done=%b exp sym=7 done=0", sym_a, done_a);
        end
      end
    end
    rx_valid = 0;
    checks++;
    if (sym_a !== 4'd8 || done_a !== 1'b1 || busy_a !== 1'b0 || rdy_a !== 1'b0) begin
      failures++; $display("FAIL clean_done got sym=%0d done=%b busy=%b rdy=%b exp 8 1 0 0", sym_a, done_a, busy_a, rdy_a);
    end
    checks++;
    if (err_a !== 5'd0) begin
      failures++; $display("FAIL clean_err got=%0d exp=0", err_a);
    end
  endtask

  task automatic test_errors;
    do_reset();
    start_a = 1; tick(); start_a = 0;
    ref_valid = 1; ref_bits = 2'b00; tick();
    ref_bits = 2'b01; tick();
    ref_bits = 2'b00; tick();
    ref_valid = 0;
    rx_valid = 1; rx_real = -24'sd5; rx_imag = -24'sd5; tick();
    checks++;
    if (err_a !== 5'(QP ? 2 : 1)) begin
      failures++; $display("FAIL err_both_neg got=%0d exp=%0d", err_a, QP ? 2 : 1);
    end
    rx_real = 24'sd0; rx_imag = 24'sd7; tick();
    checks++;
    if (err_a !== 5'(QP ? 3 : 2)) begin
      failures++; $display("FAIL err_zero got=%0d exp=%0d", err_a, QP ? 3 : 2);
    end
    rx_real = 24'sd5; rx_imag = -24'sd9; tick();
    rx_valid = 0;
    checks++;
    if (err_a !== 5'(QP ? 4 : 2) || sym_a !== 4'd3) begin
      failures++; $display("FAIL err_imag_only got err=%0d sym=%0d exp err=%0d sym=3", err_a, sym_a, QP ? 4 : 2);
    end
  endtask

  task automatic test_fifo;
    do_reset();
    start_a = 1; tick(); start_a = 0;
    ref_valid = 1; ref_bits = 2'b00; rx_valid = 1; set_rx(2'b00); tick();
    ref_valid = 0;
    checks++;
    if (unf_a !== 1'b1 || sym_a !== 4'd0) begin
      failures++; $display("FAIL underflow got unf=%b sym=%0d exp unf=1 sym=0", unf_a, sym_a);
    end
    tick();
    rx_valid = 0;
    checks++;
    if (sym_a !== 4'd1) begin
      failures++; $display("FAIL push_on_empty_kept got sym=%0d exp=1", sym_a);
    end
    for (int i = 0; i < 16; i++) begin
      ref_valid = 1; ref_bits = 2'b00; tick();
      if (i == 14) begin
        checks++;
        if (rdy_a !== 1'b1) begin
          failures++; $display("FAIL ready_at_15 got=%b exp=1", rdy_a);
        end
      end
    end
    checks++;
    if (rdy_a !== 1'b0) begin
      failures++; $display("FAIL ready_full got=%b exp=0", rdy_a);
    end
    ref_bits = 2'b11; rx_valid = 1; set_rx(2'b00); tick();
    ref_valid = 0;
    checks++;
    if (sym_a !== 4'd2 || rdy_a !== 1'b1) begin
      failures++; $display("FAIL full_push_pop got sym=%0d rdy=%b exp sym=2 rdy=1", sym_a, rdy_a);
    end
    for (int i = 0; i < 6; i++) tick();
    rx_valid = 0;
    checks++;
    if (sym_a !== 4'd8 || done_a !== 1'b1 || err_a !== 5'd0 || unf_a !== 1'b1) begin
      failures++; $display("FAIL fifo_drain got sym=%0d done=%b err=%0d unf=%b exp 8 1 0 1", sym_a, done_a, err_a, unf_a);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    start_b = 1; tick(); start_b = 0;
    for (int i = 0; i < 3; i++) begin
      ref_valid = 1; ref_bits = 2'b00; tick();
    end
    ref_valid = 0;
    rx_real = -24'sd1; rx_imag = -24'sd1;
    rx_valid = 1;
    for (int i = 0; i < 3; i++) tick();
    rx_valid = 0;
    checks++;
    if (sym_b !== 2'd3 || err_b !== 3'(QP ? 6 : 3) || done_b !== 1'b1 || busy_b !== 1'b0) begin
      failures++; $display("FAIL b_frame got sym=%0d err=%0d done=%b busy=%b exp 3 %0d 1 0", sym_b, err_b, done_b, busy_b, QP ? 6 : 3);
    end
    ref_valid = 1; rx_valid = 1; tick(); tick();
    idle_in();
    checks++;
    if (sym_b !== 2'd3 || err_b !== 3'(QP ? 6 : 3) || rdy_b !== 1'b0) begin
      failures++; $display("FAIL b_done_hold got sym=%0d err=%0d rdy=%b", sym_b, err_b, rdy_b);
    end
    start_b = 1; tick(); start_b = 0;
    checks++;
    if (sym_b !== 2'd0 || err_b !== 3'd0 || busy_b !== 1'b1 || done_b !== 1'b0 || rdy_b !== 1'b1) begin
      failures++; $display("FAIL b_restart got sym=%0d err=%0d busy=%b done=%b rdy=%b exp 0 0 1 0 1", sym_b, err_b, busy_b, done_b, rdy_b);
    end
  endtask

  initial begin
    rst = 1; idle_in(); ref_bits = 2'b00; set_rx(2'b00);
    test_reset();
    test_clean_frame();
    test_errors();
    test_fifo();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/awgn_ber_checker.md
# awgn_ber_checker

Downstream stage of the AWGN channel model. Hard-slices each noisy received symbol, compares the decided bits against the transmitted reference bits (buffered in an internal FIFO to absorb channel latency) and accumulates symbol and bit-error counts over one frame. The end-of-frame result feeds the BER-vs-SNR sweep.

## Interface
Parameters:
- BI, 24, received sample width (matches channel output width)
- FRAME_LEN, 320000, symbols per measurement frame
- DLY_DEPTH, 16, reference FIFO depth (power of two, ≥ 2)
- CNT_W, 20, symbol counter width; must satisfy 2^CNT_W > FRAME_LEN

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins a frame from IDLE or DONE
- ref_valid  in  1  reference bits valid
- ref_bits  in  2  transmitted bits; [0]=I, [1]=Q
- ref_ready  out  1  FIFO can accept reference bits
- rx_valid  in  1  received symbol valid
- rx_real  in  BI  signed received I sample
- rx_imag  in  BI  signed received Q sample
- busy  out  1  high in RUN
- done  out  1  high in DONE
- sym_count  out  CNT_W  symbols compared this frame
- err_count  out  CNT_W+1  bit errors this frame, saturating
- underflow  out  1  sticky: rx_valid arrived with FIFO empty

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: start → RUN; clears sym_count, err_count, underflow, FIFO.
- RUN: start ignored. Reference push when ref_valid && ref_ready. ref_ready = (FIFO occupancy < DLY_DEPTH); computed from registered occupancy only, so no push into a full FIFO even when a pop occurs in the same cycle.
- rx_valid in RUN with FIFO non-empty: pop one entry; slice: decided bit = 1 if sample < 0, else 0 (exact zero decides 0); bit errors = popcount(decided XOR popped ref); sym_count += 1; err_count += errors, saturating at all-ones.
- rx_valid in RUN with FIFO empty (before the push registers, i.e. simultaneous push/pop on empty): no pop, no count; underflow set. The pushed entry is still stored.
- When the increment makes sym_count == FRAME_LEN: → DONE next edge. Further rx_valid/ref_valid in DONE are ignored; ref_ready = 0 outside RUN.
- DONE: counters and underflow held; start → RUN with full clear (same as IDLE).
- rx_valid / ref_valid in IDLE: ignored.

## Timing
- Reset values: ref_ready 0, busy 0, done 0, sym_count 0, err_count 0, underflow 0; FIFO empty.
- Reset is asynchronous at assertion; deassertion is sampled on the next rising edge. Reset mid-frame discards the frame and FIFO contents.
- start sampled at edge N → busy=1 and ref_ready=1 after edge N.
- rx_valid at edge N → sym_count/err_count updated after edge N (1-cycle latency, registered).
- Final symbol at edge N → busy=0, done=1 after edge N; counts already final at that point.
- FIFO occupancy, pointers wrap modulo DLY_DEPTH; full/empty derived from an occupancy counter of width log2(DLY_DEPTH)+1.

## Configuration
- QPSK_EN defined: both I and Q sliced and compared; up to 2 errors per symbol; rx_imag and ref_bits[1] used.
- QPSK_EN undefined (BPSK): only rx_real vs ref_bits[0]; max 1 error per symbol; rx_imag, ref_bits[1] ignored (no logic). Port list and widths identical in both builds.

## Test plan
- Reset: assert reset mid-RUN with 5 entries queued → all outputs 0 asynchronously, state IDLE, ref_ready 0.
- Clean frame (FRAME_LEN=8, QPSK_EN): start, push refs 0..3 cycling, feed rx = +1000/-1000 matching → done after 8th rx, sym_count=8, err_count=0.
- Error counting (QPSK_EN): ref 2'b00, rx_real=-5, rx_imag=-5 → err_count +2; ref 2'b01, rx_real=0, rx_imag=7 → err_count +1 (zero decides 0).
- BPSK build: same stimulus as previous → errors +1 then +1; rx_imag changes have no effect.
- FIFO boundaries: push 16 with no rx → ref_ready 0 after 16th; simultaneous ref_valid and rx_valid when full → pop only, occupancy 15; rx_valid on empty → underflow=1, sym_count unchanged.
- Saturation/restart: CNT_W=2, FRAME_LEN=3, QPSK_EN, all 3 symbols doubly wrong → err_count=6 (3-bit field, no saturation reached); force 4+ errors with FRAME_LEN=3, CNT_W=2 impossible, so use CNT_W=2, FRAME_LEN=3 BPSK and verify err_count=3; then start in DONE → counters 0, busy 1.
